tlc_phase_ctrl: RTL and testbench
=================================

Name: tlc_phase_ctrl

Overview:
- Parametrised N-phase traffic-light controller: successor to the two-road J/C yellow/green controller.
- Rotates green through NPH phases with yellow and all-red clearance intervals.
- Adds a latched pedestrian walk interval, a flashing-yellow night mode, an enable/freeze input and runtime per-phase green times.
- Sits between the road-sensor/pushbutton synchroniser and the lamp drivers; all timing is in ticks from an internal prescaler.

Parameters:
- NPH, 2, number of vehicle phases (2..8)
- CW, 12, width of tick counters and of each green_time field
- TICK_DIV, 2, clocks per tick (>=1)
- YELLOW_T, 3, yellow duration in ticks (>=1)
- ALLRED_T, 1, all-red clearance in ticks (>=1)
- WALK_T, 5, pedestrian walk duration in ticks (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  1 = run; 0 = freeze prescaler and counters, hold lamps
- night  in  1  level; 1 = night flashing mode
- ped_req  in  1  pedestrian request pulse (already synchronised)
- green_time  in  NPH*CW  per-phase green duration in ticks; phase i at [i*CW +: CW]
- green  out  NPH  per-phase green lamp
- yellow  out  NPH  per-phase yellow lamp
- red  out  NPH  per-phase red lamp
- walk  out  1  pedestrian walk lamp
- phase_idx  out  clog2(NPH)  current/last served phase
- tick  out  1  one-clock prescaler pulse (debug/visibility)

Behaviour:
- Reset (rst=1 at a clk edge): state=ALLRED, phase_idx=NPH-1, red=all 1, green=0, yellow=0, walk=0, prescaler=0, ped_pend=0, duration counter=ALLRED_T-1.
- Prescaler counts 0..TICK_DIV-1 while en=1. tick=1 in the cycle it equals TICK_DIV-1. It is cleared on every state entry, so each state lasts exactly duration*TICK_DIV enabled clocks.
- Duration counter is loaded with duration-1 on state entry. On each tick it decrements, or transitions when it is 0.
- A green_time field of 0 is treated as 1.
- States and exits (all on a tick with counter=0):
  - GREEN(p) -> YELLOW(p)
  - YELLOW(p) -> ALLRED
  - ALLRED -> WALK if ped_pend, else GREEN((phase_idx+1) mod NPH), updating phase_idx
  - WALK -> GREEN((phase_idx+1) mod NPH)
- Lamps are a Moore decode of registered state and phase_idx only, with no input-to-output path:
  - GREEN(p): green[p]=1, all other red=1.
  - YELLOW(p): yellow[p]=1, all other red=1.
  - ALLRED/WALK: red=all 1; walk=1 only in WALK.
- ped_pend is set by ped_req in any state and any en value. It is cleared on WALK entry. A ped_req during WALK re-arms it for the next cycle of phases.
- NIGHT: when night=1, the next clock enters NIGHT from any state and clears ped_pend. In NIGHT, green=0, red=0, walk=0, and yellow=all 1 toggling on each tick, starting lit.
- Leaving NIGHT: night=0 exits to ALLRED with phase_idx=NPH-1, so phase 0 is served first.
- Simultaneous events, in priority order: rst > night > en=0 freeze > normal transition.
- en=0: no state, counter or prescaler change; ped_req is still latched.
- rst mid-state aborts immediately to the reset values. green_time is sampled only on GREEN entry.

Optional Feature:
- Macro: TLC_CONFLICT_MON_EN.
- Defined:
  - Adds output fault (1 bit, reset 0).
  - Outside NIGHT, fault sets sticky if popcount(green|yellow)>1, or if walk=1 while any green/yellow=1.
  - While fault=1, lamps are forced to red=all 1, green=yellow=walk=0 until rst.
- Undefined: no fault port and no monitor logic; behaviour otherwise identical.

Decomposition:
- Package tlc_pkg:
  - state enum (ALLRED, GREEN, YELLOW, WALK, NIGHT) with fixed 3-bit encoding
  - width helper for phase_idx (clog2 with minimum 1)
  - lamp-vector constants
- Sub-module tlc_tick_gen: prescaler with en and sync clear, producing tick.

Test Plan (defaults; green_time phase0=10, phase1=13; en=1):
- Reset release, run: ALLRED 2 clk -> green[0] 20 clk -> yellow[0] 6 clk -> ALLRED 2 clk -> green[1] 26 clk -> yellow[1] 6 clk -> back to phase 0; red[~p]=1 throughout.
- ped_req pulse during green[0]: after yellow[0] and ALLRED, walk=1 for 10 clk with red=2'b11, then green[1]; ped_pend cleared.
- night=1 mid green[1]: next clk green=0, yellow=2'b11, toggling every 2 clk; night=0 -> ALLRED 2 clk -> green[0].
- en=0 for 7 clk mid yellow[0]: lamps and counters hold; total yellow = 6 enabled clk + 7 frozen; ped_req during freeze is served next ALLRED.
- green_time phase1=0: green[1] lasts 2 clk; rst asserted mid-WALK: next clk red=all 1, walk=0, state ALLRED.
- With TLC_CONFLICT_MON_EN: force green=2'b11 via state corruption -> fault=1 next clk, all red until rst.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and helpers for the N-phase traffic-light controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WALK   = 3'd3,
    ST_NIGHT  = 3'd4
  } tlc_state_e;

  localparam int MAX_NPH = 8;
  localparam logic [MAX_NPH-1:0] LAMPS_ON  = '1;
  localparam logic [MAX_NPH-1:0] LAMPS_OFF = '0;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Tick prescaler: one-clock tick every TICK_DIV enabled clocks, restartable on state entry.
module tlc_tick_gen
  import tlc_pkg::*;
#(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = idx_w(TICK_DIV);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      pcnt <= '0;
    else if (en)
      pcnt <= tick ? '0 : pcnt + 1'b1;
  end

endmodule

// File: rtl/tlc_phase_ctrl.sv
// N-phase traffic-light controller with walk interval, night flash and freeze.
// Optional lamp-conflict monitor with sticky fault output: define TLC_CONFLICT_MON_EN.
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int NPH      = 2,
  parameter int CW       = 12,
  parameter int TICK_DIV = 2,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   night,
  input  logic                   ped_req,
  input  logic [NPH*CW-1:0]      green_time,
  output logic [NPH-1:0]         green,
  output logic [NPH-1:0]         yellow,
  output logic [NPH-1:0]         red,
  output logic                   walk,
  output logic [idx_w(NPH)-1:0]  phase_idx,
  output logic                   tick
`ifdef TLC_CONFLICT_MON_EN
  ,
  output logic                   fault
`endif
);

  localparam int PW = idx_w(NPH);

  tlc_state_e    state, state_d;
  logic [PW-1:0] phase_d, phase_nxt;
  logic [CW-1:0] cnt, cnt_d, gt_nxt, green_ld;
  logic          enter;
  logic          night_lit;
  logic          ped_pend;

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (enter),
    .tick (tick)
  );

  assign phase_nxt = (phase_idx == PW'(NPH - 1)) ? '0 : phase_idx + 1'b1;
  assign gt_nxt    = green_time[int'(phase_nxt)*CW +: CW];
  // A zero green time still gets one tick.
  assign green_ld  = (gt_nxt == '0) ? '0 : gt_nxt - 1'b1;

  always_comb begin
    state_d = state;
    phase_d = phase_idx;
    cnt_d   = cnt;
    enter   = 1'b0;
    if (night) begin
      if (state != ST_NIGHT) begin
        state_d = ST_NIGHT;
        cnt_d   = '0;
        enter   = 1'b1;
      end
    end else if (en) begin
      if (state == ST_NIGHT) begin
        // Restart the rotation so phase 0 is served first.
        state_d = ST_ALLRED;
        phase_d = PW'(NPH - 1);
        cnt_d   = CW'(ALLRED_T - 1);
        enter   = 1'b1;
      end else if (tick) begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          enter = 1'b1;
          case (state)
            ST_GREEN: begin
              state_d = ST_YELLOW;
              cnt_d   = CW'(YELLOW_T - 1);
            end
            ST_YELLOW: begin
              state_d = ST_ALLRED;
              cnt_d   = CW'(ALLRED_T - 1);
            end
            ST_ALLRED: begin
              if (ped_pend) begin
                state_d = ST_WALK;
                cnt_d   = CW'(WALK_T - 1);
              end else begin
                state_d = ST_GREEN;
                phase_d = phase_nxt;
                cnt_d   = green_ld;
              end
            end
            ST_WALK: begin
              state_d = ST_GREEN;
              phase_d = phase_nxt;
              cnt_d   = green_ld;
            end
            default: begin
              state_d = ST_ALLRED;
              cnt_d   = CW'(ALLRED_T - 1);
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ALLRED;
      phase_idx <= PW'(NPH - 1);
      cnt       <= CW'(ALLRED_T - 1);
      night_lit <= 1'b0;
      ped_pend  <= 1'b0;
    end else begin
      state     <= state_d;
      phase_idx <= phase_d;
      cnt       <= cnt_d;
      if (enter && state_d == ST_NIGHT)
        night_lit <= 1'b1;
      else if (state == ST_NIGHT && tick)
        night_lit <= ~night_lit;
      // A request arriving on the WALK entry clock re-arms for the next round.
      if (night)
        ped_pend <= 1'b0;
      else if (ped_req)
        ped_pend <= 1'b1;
      else if (enter && state_d == ST_WALK)
        ped_pend <= 1'b0;
    end
  end

  logic [NPH-1:0] g_raw, y_raw, r_raw;
  logic           w_raw;

  for (genvar i = 0; i < NPH; i++) begin : g_lamp
    assign g_raw[i] = (state == ST_GREEN) && (phase_idx == PW'(i));
    assign y_raw[i] = (state == ST_NIGHT) ? night_lit
                                          : ((state == ST_YELLOW) && (phase_idx == PW'(i)));
    assign r_raw[i] = (state != ST_NIGHT) && !g_raw[i] && !y_raw[i];
  end
  assign w_raw = (state == ST_WALK);

`ifdef TLC_CONFLICT_MON_EN
  logic conflict;

  assign conflict = (state != ST_NIGHT) &&
                    (($countones(g_raw | y_raw) > 1) || (w_raw && |(g_raw | y_raw)));

  always_ff @(posedge clk) begin
    if (rst)
      fault <= 1'b0;
    else if (conflict)
      fault <= 1'b1;
  end

  assign green  = fault ? LAMPS_OFF[NPH-1:0] : g_raw;
  assign yellow = fault ? LAMPS_OFF[NPH-1:0] : y_raw;
  assign red    = fault ? LAMPS_ON[NPH-1:0]  : r_raw;
  assign walk   = fault ? 1'b0 : w_raw;
`else
  assign green  = g_raw;
  assign yellow = y_raw;
  assign red    = r_raw;
  assign walk   = w_raw;
`endif

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Directed-vector bench for tlc_phase_ctrl with an expected-lamp scoreboard.
module tb_tlc_phase_ctrl;

  localparam int NPH = 2;
  localparam int CW  = 12;

  logic              clk = 1'b0;
  logic              rst, en, night, ped_req;
  logic [NPH*CW-1:0] green_time;
  logic [NPH-1:0]    green, yellow, red;
  logic              walk;
  logic [0:0]        phase_idx;
  logic              tick;
`ifdef TLC_CONFLICT_MON_EN
  logic              fault;
`endif

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] y;
    logic [1:0] r;
    logic       w;
    logic       p;
  } lamps_t;

  typedef struct {
    lamps_t l;
    int     tag;
  } exp_t;

  // Expected lamp sets: {green, yellow, red, walk, phase_idx}
  localparam lamps_t AR1 = {2'b00, 2'b00, 2'b11, 1'b0, 1'b1};
  localparam lamps_t AR0 = {2'b00, 2'b00, 2'b11, 1'b0, 1'b0};
  localparam lamps_t G0  = {2'b01, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam lamps_t Y0  = {2'b00, 2'b01, 2'b10, 1'b0, 1'b0};
  localparam lamps_t G1  = {2'b10, 2'b00, 2'b01, 1'b0, 1'b1};
  localparam lamps_t Y1  = {2'b00, 2'b10, 2'b01, 1'b0, 1'b1};
  localparam lamps_t W0  = {2'b00, 2'b00, 2'b11, 1'b1, 1'b0};
  localparam lamps_t NL1 = {2'b00, 2'b11, 2'b00, 1'b0, 1'b1};
  localparam lamps_t ND1 = {2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

  exp_t   sb[$];
  exp_t   e;
  lamps_t act;
  int     n_vec = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  tlc_phase_ctrl #(
    .NPH(NPH), .CW(CW), .TICK_DIV(2), .YELLOW_T(3), .ALLRED_T(1), .WALK_T(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .night      (night),
    .ped_req    (ped_req),
    .green_time (green_time),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .walk       (walk),
    .phase_idx  (phase_idx),
    .tick       (tick)
`ifdef TLC_CONFLICT_MON_EN
    ,
    .fault      (fault)
`endif
  );

  // Each call advances n clocks; inputs set beforehand apply at the first edge.
  task automatic seg(input int n, input lamps_t l, input int tag);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      x.l   = l;
      x.tag = tag;
      sb.push_back(x);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {green, yellow, red, walk, phase_idx};
        n_vec++;
        if (act !== e.l) begin
          n_bad++;
          $display("FAIL lamps tag=%0d t=%0t got g=%b y=%b r=%b w=%b p=%b want g=%b y=%b r=%b w=%b p=%b",
                   e.tag, $time, green, yellow, red, walk, phase_idx,
                   e.l.g, e.l.y, e.l.r, e.l.w, e.l.p);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    night      = 1'b0;
    ped_req    = 1'b0;
    green_time = {12'd13, 12'd10};

    // reset state, then one full rotation
    seg(2, AR1, 0);
    rst = 1'b0;
    seg(1, AR1, 1);
    seg(20, G0, 2);
    seg(6, Y0, 3);
    seg(2, AR0, 4);
    seg(26, G1, 5);
    seg(6, Y1, 6);
    seg(2, AR1, 7);

    // pedestrian request during green[0]
    seg(5, G0, 8);
    ped_req = 1'b1;
    seg(1, G0, 8);
    ped_req = 1'b0;
    seg(14, G0, 8);
    seg(6, Y0, 9);
    seg(2, AR0, 10);
    seg(10, W0, 11);
    seg(10, G1, 12);

    // night mode mid green[1]
    night = 1'b1;
    seg(2, NL1, 13);
    seg(2, ND1, 13);
    seg(2, NL1, 13);
    seg(2, ND1, 13);
    night = 1'b0;
    seg(2, AR1, 14);
    seg(20, G0, 15);

    // freeze mid yellow[0], request latched while frozen
    seg(3, Y0, 16);
    en = 1'b0;
    seg(3, Y0, 16);
    ped_req = 1'b1;
    seg(1, Y0, 16);
    ped_req = 1'b0;
    seg(3, Y0, 16);
    en = 1'b1;
    seg(3, Y0, 16);
    seg(2, AR0, 17);
    green_time[CW +: CW] = '0;
    seg(10, W0, 18);
    seg(2, G1, 19);
    seg(6, Y1, 20);
    seg(2, AR1, 21);

    // walk not repeated; then reset mid-walk
    seg(3, G0, 22);
    ped_req = 1'b1;
    seg(1, G0, 22);
    ped_req = 1'b0;
    seg(16, G0, 22);
    seg(6, Y0, 23);
    seg(2, AR0, 24);
    seg(4, W0, 25);
    rst = 1'b1;
    seg(1, AR1, 26);
    rst = 1'b0;
    seg(1, AR1, 27);
    seg(4, G0, 28);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected records never compared", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
